// File: rtl/reg_pkg.sv
// Shared defaults and FSM state type for the register access controller.
// Consumers: reg_access_ctrl, reg_scoreboard (both honour REG_ACCESS_BYPASS_EN).
package reg_pkg;

    localparam int unsigned DefWord     = 8;
    localparam int unsigned DefRegSize  = 4;
    localparam int unsigned DefAddrSize = $clog2(DefRegSize);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StHold = 2'd2
    } state_e;

    // A single-register file still needs a one-bit index.
    function automatic int unsigned addr_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// With REG_ACCESS_BYPASS_EN defined, a same-cycle writeback clear is visible to the hazard lookup.
module reg_scoreboard
    import reg_pkg::*;
#(
    parameter int unsigned REG_SIZE  = DefRegSize,
    parameter int unsigned ADDR_SIZE = DefAddrSize
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_en,
    input  logic [ADDR_SIZE-1:0] set_addr,
    input  logic                 clr_en,
    input  logic [ADDR_SIZE-1:0] clr_addr,
    input  logic [ADDR_SIZE-1:0] chk_src1,
    input  logic [ADDR_SIZE-1:0] chk_src2,
    input  logic [ADDR_SIZE-1:0] chk_dst,
    output logic                 hazard
);

    logic [REG_SIZE-1:0] pending_q;
    logic [REG_SIZE-1:0] pending_d;
    logic [REG_SIZE-1:0] pending_clr;

    always_comb begin
        pending_clr = pending_q;
        if (clr_en) begin
            pending_clr[clr_addr] = 1'b0;
        end
    end

    // Set is applied after clear so an issue to the register being written back stays pending.
    always_comb begin
        pending_d = pending_clr;
        if (set_en) begin
            pending_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

`ifdef REG_ACCESS_BYPASS_EN
    assign hazard = pending_clr[chk_src1] | pending_clr[chk_src2] | pending_clr[chk_dst];
`else
    assign hazard = pending_q[chk_src1] | pending_q[chk_src2] | pending_q[chk_dst];
`endif

endmodule

// File: rtl/reg_access_ctrl.sv
// Operand fetch controller: hazard-checked issue, register file read, operand hold until consumed.
// REG_ACCESS_BYPASS_EN enables same-cycle writeback forwarding into the operand path.
module reg_access_ctrl
    import reg_pkg::*;
#(
    parameter int unsigned  WORD      = DefWord,
    parameter int unsigned  REG_SIZE  = DefRegSize,
    localparam int unsigned ADDR_SIZE = addr_bits(REG_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_SIZE-1:0] req_src1,
    input  logic [ADDR_SIZE-1:0] req_src2,
    input  logic [ADDR_SIZE-1:0] req_dst,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [WORD-1:0]      op_a,
    output logic [WORD-1:0]      op_b,
    output logic [ADDR_SIZE-1:0] op_dst,
    input  logic                 wb_valid,
    input  logic [ADDR_SIZE-1:0] wb_addr,
    input  logic [WORD-1:0]      wb_data,
    output logic [ADDR_SIZE-1:0] rf_rd_addr1,
    output logic [ADDR_SIZE-1:0] rf_rd_addr2,
    input  logic [WORD-1:0]      rf_rd_data1,
    input  logic [WORD-1:0]      rf_rd_data2,
    output logic                 rf_wr_en,
    output logic [ADDR_SIZE-1:0] rf_wr_addr,
    output logic [WORD-1:0]      rf_wr_data
);

    state_e state_q, state_d;

    logic                 wb_en;
    logic                 hazard;
    logic                 accept;
    logic [ADDR_SIZE-1:0] src1_q, src1_d;
    logic [ADDR_SIZE-1:0] src2_q, src2_d;
    logic [ADDR_SIZE-1:0] dst_q, dst_d;
    logic [WORD-1:0]      op_a_q, op_a_d;
    logic [WORD-1:0]      op_b_q, op_b_d;
    logic [WORD-1:0]      rd_val1;
    logic [WORD-1:0]      rd_val2;

    // Writes are suppressed while reset is asserted, whatever wb_valid does.
    assign wb_en  = wb_valid & rst_n;
    assign accept = req_valid & req_ready;

    reg_scoreboard #(
        .REG_SIZE  (REG_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (accept),
        .set_addr (req_dst),
        .clr_en   (wb_en),
        .clr_addr (wb_addr),
        .chk_src1 (req_src1),
        .chk_src2 (req_src2),
        .chk_dst  (req_dst),
        .hazard   (hazard)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRead;
            StRead:  state_d = StHold;
            StHold:  if (op_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready   = 1'b0;
        op_valid    = 1'b0;
        rf_rd_addr1 = src1_q;
        rf_rd_addr2 = src2_q;
        unique case (state_q)
            StIdle: begin
                req_ready   = ~hazard;
                rf_rd_addr1 = req_src1;
                rf_rd_addr2 = req_src2;
            end
            StHold:  op_valid = 1'b1;
            default: ;
        endcase
    end

`ifdef REG_ACCESS_BYPASS_EN
    // The file samples its read address on the same edge the writeback lands, so it returns
    // the old value; remember the writeback and substitute it when the read data is captured.
    logic            fwd1_q, fwd1_d;
    logic            fwd2_q, fwd2_d;
    logic [WORD-1:0] fwd_data_q, fwd_data_d;

    always_comb begin
        fwd1_d     = fwd1_q;
        fwd2_d     = fwd2_q;
        fwd_data_d = fwd_data_q;
        if (accept) begin
            fwd1_d     = wb_en && (wb_addr == req_src1);
            fwd2_d     = wb_en && (wb_addr == req_src2);
            fwd_data_d = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd1_q     <= 1'b0;
            fwd2_q     <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd1_q     <= fwd1_d;
            fwd2_q     <= fwd2_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign rd_val1 = fwd1_q ? fwd_data_q : rf_rd_data1;
    assign rd_val2 = fwd2_q ? fwd_data_q : rf_rd_data2;
`else
    assign rd_val1 = rf_rd_data1;
    assign rd_val2 = rf_rd_data2;
`endif

    always_comb begin
        src1_d = src1_q;
        src2_d = src2_q;
        dst_d  = dst_q;
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        if (accept) begin
            src1_d = req_src1;
            src2_d = req_src2;
            dst_d  = req_dst;
        end
        if (state_q == StRead) begin
            op_a_d = rd_val1;
            op_b_d = rd_val2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src1_q <= '0;
            src2_q <= '0;
            dst_q  <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
        end else begin
            src1_q <= src1_d;
            src2_q <= src2_d;
            dst_q  <= dst_d;
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
        end
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_dst     = dst_q;
    assign rf_wr_en   = wb_en;
    assign rf_wr_addr = wb_addr;
    assign rf_wr_data = wb_data;

endmodule
